s2_cell_array: RTL and testbench
================================

# s2_cell_array

Parametrised array of CHANNELS sequential S-type logic cells whose per-channel mux data is loaded from a serial configuration bitstream rather than driven from ports. It is the programmable successor to the single 4-input S-cell and is the building block for the FPGA-programmed neural-network fabric. A small FSM loads the configuration, then runs the cells. Each cell evaluates a 2^SEL_LEVELS-input AND/OR-gated mux tree into a registered output.

## Interface
- CHANNELS, 4, number of independent cells
- SEL_LEVELS, 2, mux-tree depth; each cell holds D = 2^SEL_LEVELS config bits
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration bit valid
- cfg_bit  in  1  configuration bit
- cfg_ready  out  1  array accepts a config bit this cycle
- cfg_done  out  1  configuration complete, array running
- reconfig  in  1  request return to LOAD (sampled in RUN only)
- run_en  in  1  output register update enable
- sclr  in  1  synchronous clear of q
- a  in  CHANNELS*SEL_LEVELS  select inputs A; channel c level k = a[c*SEL_LEVELS+k]
- b  in  CHANNELS*SEL_LEVELS  select inputs B, same packing
- q  out  CHANNELS  registered cell outputs

## Operation
- N = CHANNELS*D config bits; counter width $clog2(N+1).
- States:
  - LOAD (reset state): cfg_ready=1, cfg_done=0.
  - RUN: cfg_ready=0, cfg_done=1.
- LOAD:
  - Accept a bit on cfg_valid&cfg_ready: cfg_reg <= {cfg_bit, cfg_reg[N-1:1]}, count+1.
  - The first bit sent ends in cfg_reg[0].
  - When the N-th bit is accepted: count clears, go to RUN.
- RUN:
  - reconfig=1: count clears, go to LOAD. cfg_reg is not cleared; it is overwritten bit by bit.
- Cell c data d = cfg_reg[c*D +: D].
- Select bits:
  - s0 = a0 & b0.
  - sk = ak | bk for k≥1.
- Cell value = d[{s_{L-1}..s_0}].
- q update priority:
  - sclr → q[c] <= 0.
  - else run_en in RUN → q[c] <= cell value.
  - else q holds.
- q never updates from the mux in LOAD; it holds its last value, and sclr still works.
- reconfig and run_en in the same RUN cycle: q updates using the old config, then the state becomes LOAD.
- reconfig in LOAD is ignored. cfg_valid in RUN is ignored.
- clr low in mid-load or mid-run: state=LOAD, count=0, cfg_reg=0, q=0, immediately and asynchronously.

## Timing
- Reset values:
  - q=0, cfg_ready=1, cfg_done=0.
  - cfg_reg=0, count=0, cfg_out=0.
- Config handshake: bit transfers on the rising edge where cfg_valid&cfg_ready=1. No combinational path from cfg_valid to cfg_ready.
- cfg_done rises one cycle after the edge that accepts the N-th bit. cfg_ready falls in the same cycle.
- Minimum load time is N cycles. Gaps in cfg_valid stall the load without loss.
- q latency: 1 cycle from a/b/run_en to q. The select path is purely combinational into the q flop.
- cfg_done falls one cycle after reconfig is sampled in RUN.

## Configuration
- S2_CFG_READBACK_EN, defined:
  - Adds output cfg_out (1 bit) = cfg_reg[0] before each shift, registered.
  - Every accepted bit pushes the old bit 0 out, so arrays can be daisy-chained and the old bitstream read back during reload.
  - cfg_out resets to 0.
- Undefined: no cfg_out port and no readback flop. All other behaviour is identical.

## Structure
- Package s2_pkg holds:
  - State typedef (LOAD, RUN).
  - Localparam helper for D and N.
  - Function computing the select index from a/b slices.
- Sub-module s2_mux_cell: one combinational cell, parameter SEL_LEVELS; inputs d, a, b; output y.
- The top instantiates CHANNELS copies in a generate loop. The FSM, counter, cfg_reg and q flops live in the top.

## Test plan
All scenarios use CHANNELS=2, SEL_LEVELS=2 (N=8), bitstream 0,1,1,0,1,1,1,1, giving ch0 d=4'b0110 and ch1 d=4'b1111.
- Reset then load 8 bits back-to-back → cfg_ready low and cfg_done high exactly 1 cycle after the 8th bit; q=2'b00 throughout the load.
- All a=b=1, run_en=1 → after 1 clk q=2'b10 (ch0 index 3 → 0).
- ch0 b0=0, other selects 1 → ch0 index 2, q[0]=1.
- ch0 a1=b1=0, a0=b0=1 → index 1, q[0]=1. sclr=1 with run_en=1 → q=2'b00 next cycle.
- Load with cfg_valid toggling every other cycle → load takes 16 cycles and ends with the same config and q results. reconfig with run_en in RUN → q updates once, then cfg_ready=1 and q frozen.
- clr pulse at bit 5 of a load → immediate q=0, cfg_ready=1, count=0. A full 8-bit reload then works. With S2_CFG_READBACK_EN, a second load of all-zeros emits 0,1,1,0,1,1,1,1 on cfg_out.

Source files
------------

// File: rtl/s2_pkg.sv
// Shared types and helpers for the s2_cell_array programmable S-cell fabric.
package s2_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest select tree the index helper supports.
    localparam int MAX_SEL = 8;

    function automatic int cell_d(input int sel_levels);
        return 1 << sel_levels;
    endfunction

    function automatic int cfg_n(input int channels, input int sel_levels);
        return channels * cell_d(sel_levels);
    endfunction

    // Level 0 is AND-gated, every higher level is OR-gated.
    function automatic logic [MAX_SEL-1:0] sel_index(input logic [MAX_SEL-1:0] a,
                                                     input logic [MAX_SEL-1:0] b,
                                                     input int levels);
        logic [MAX_SEL-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_SEL; k++) begin
            if (k < levels) begin
                idx[k] = (k == 0) ? (a[k] & b[k]) : (a[k] | b[k]);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/s2_mux_cell.sv
// One combinational S-cell: AND/OR-gated select tree over D config bits.
module s2_mux_cell
    import s2_pkg::*;
#(
    parameter int SEL_LEVELS = 2
) (
    input  logic [(1<<SEL_LEVELS)-1:0] d,
    input  logic [SEL_LEVELS-1:0]      a,
    input  logic [SEL_LEVELS-1:0]      b,
    output logic                       y
);
    localparam int DEXT = 1 << MAX_SEL;

    logic [MAX_SEL-1:0] a_ext, b_ext, idx;
    logic [DEXT-1:0]    d_ext;

    assign a_ext = MAX_SEL'(a);
    assign b_ext = MAX_SEL'(b);
    assign d_ext = DEXT'(d);
    assign idx   = sel_index(a_ext, b_ext, SEL_LEVELS);
    assign y     = d_ext[idx];

endmodule

// File: rtl/s2_cell_array.sv
// Array of serially configured S-cells with a LOAD/RUN controller.
// Optional readback/daisy-chain output enabled by S2_CFG_READBACK_EN.
module s2_cell_array
    import s2_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int SEL_LEVELS = 2
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           cfg_valid,
    input  logic                           cfg_bit,
    output logic                           cfg_ready,
    output logic                           cfg_done,
    input  logic                           reconfig,
    input  logic                           run_en,
    input  logic                           sclr,
    input  logic [CHANNELS*SEL_LEVELS-1:0] a,
    input  logic [CHANNELS*SEL_LEVELS-1:0] b,
`ifdef S2_CFG_READBACK_EN
    output logic                           cfg_out,
`endif
    output logic [CHANNELS-1:0]            q
);
    localparam int D  = cell_d(SEL_LEVELS);
    localparam int N  = cfg_n(CHANNELS, SEL_LEVELS);
    localparam int CW = $clog2(N + 1);

    state_t                state, state_nx;
    logic [N-1:0]          cfg_reg;
    logic [CW-1:0]         count;
    logic [CHANNELS-1:0]   cell_y;
    logic                  accept, last;

    assign accept = cfg_valid & (state == LOAD);
    assign last   = (count == CW'(N - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= LOAD;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        case (state)
            LOAD: begin
                cfg_ready = 1'b1;
                if (accept && last) state_nx = RUN;
            end
            RUN: begin
                cfg_done = 1'b1;
                if (reconfig) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    // First bit shifted in ends up in cfg_reg[0] after N accepts.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cfg_reg <= '0;
            count   <= '0;
        end else if (accept) begin
            cfg_reg <= {cfg_bit, cfg_reg[N-1:1]};
            count   <= last ? '0 : count + 1'b1;
        end else if (state == RUN && reconfig) begin
            count   <= '0;
        end
    end

`ifdef S2_CFG_READBACK_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)        cfg_out <= 1'b0;
        else if (accept) cfg_out <= cfg_reg[0];
    end
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
        s2_mux_cell #(.SEL_LEVELS(SEL_LEVELS)) u_cell (
            .d (cfg_reg[c*D +: D]),
            .a (a[c*SEL_LEVELS +: SEL_LEVELS]),
            .b (b[c*SEL_LEVELS +: SEL_LEVELS]),
            .y (cell_y[c])
        );
    end

    // In LOAD the outputs freeze so a half-written config never reaches q.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                       q <= '0;
        else if (sclr)                  q <= '0;
        else if (run_en && state == RUN) q <= cell_y;
    end

endmodule

// File: tb/tb_s2_cell_array.sv
// Directed, table-driven bench for s2_cell_array (CHANNELS=2, SEL_LEVELS=2).
module tb_s2_cell_array;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       cfg_valid = 1'b0, cfg_bit = 1'b0;
    logic       cfg_ready, cfg_done;
    logic       reconfig = 1'b0, run_en = 1'b0, sclr = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic [1:0] q;
`ifdef S2_CFG_READBACK_EN
    logic       cfg_out;
`endif

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sclr;
        logic       run_en;
        logic [1:0] q;
    } vec_t;

    vec_t tbl[9];

    // Sent first-to-last as bit 0..7: 0,1,1,0,1,1,1,1 -> ch0 d=0110, ch1 d=1111.
    localparam logic [7:0] STREAM = 8'b1111_0110;

    s2_cell_array #(.CHANNELS(2), .SEL_LEVELS(2)) dut (
        .clk       (clk),
        .clr       (clr),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .reconfig  (reconfig),
        .run_en    (run_en),
        .sclr      (sclr),
        .a         (a),
        .b         (b),
`ifdef S2_CFG_READBACK_EN
        .cfg_out   (cfg_out),
`endif
        .q         (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads 8 bits; optional idle cycle before each bit. q must hold q_hold.
    task automatic load(input logic [7:0] stream, input bit gapped,
                        input logic [1:0] q_hold, input bit chk_out,
                        input logic [7:0] old_stream);
        int cyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (gapped) begin
                cfg_valid = 1'b0;
                step();
                cyc++;
            end
            chk("load_ready", cfg_ready, 1'b1);
            cfg_valid = 1'b1;
            cfg_bit   = stream[i];
            step();
            cyc++;
            chk("load_q_hold", q, q_hold);
`ifdef S2_CFG_READBACK_EN
            if (chk_out) chk("readback", cfg_out, old_stream[i]);
`else
            if (chk_out) chk("readback_none", old_stream[i], old_stream[i] ^ 1'b0);
`endif
            if (i == 6) chk("done_early", cfg_done, 1'b0);
        end
        cfg_valid = 1'b0;
        chk("load_done", cfg_done, 1'b1);
        chk("load_ready_low", cfg_ready, 1'b0);
        chk("load_cycles", cyc, gapped ? 16 : 8);
    endtask

    task automatic run_table();
        for (int i = 0; i < 9; i++) begin
            a      = tbl[i].a;
            b      = tbl[i].b;
            sclr   = tbl[i].sclr;
            run_en = tbl[i].run_en;
            step();
            chk($sformatf("vec%0d", i), q, tbl[i].q);
        end
        sclr   = 1'b0;
        run_en = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 2'b10}; // both idx3
        tbl[1] = '{4'b1111, 4'b1110, 1'b0, 1'b1, 2'b11}; // ch0 idx2
        tbl[2] = '{4'b1101, 4'b1101, 1'b0, 1'b1, 2'b11}; // ch0 idx1
        tbl[3] = '{4'b1100, 4'b1100, 1'b0, 1'b1, 2'b10}; // ch0 idx0
        tbl[4] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'b10}; // both idx0
        tbl[5] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 2'b00}; // sclr wins
        tbl[6] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 2'b10};
        tbl[7] = '{4'b1110, 4'b1110, 1'b0, 1'b0, 2'b10}; // hold
        tbl[8] = '{4'b1110, 4'b1110, 1'b1, 1'b0, 2'b00}; // sclr alone

        #12;
        chk("rst_q", q, 2'b00);
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_done", cfg_done, 1'b0);
`ifdef S2_CFG_READBACK_EN
        chk("rst_cfg_out", cfg_out, 1'b0);
`endif
        clr = 1'b1;
        step();

        // reconfig in LOAD is ignored
        reconfig = 1'b1;
        step();
        reconfig = 1'b0;
        chk("reconfig_in_load", cfg_ready, 1'b1);

        load(STREAM, 1'b0, 2'b00, 1'b0, 8'h00);
        // cfg_valid in RUN is ignored
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("valid_in_run", cfg_done, 1'b1);
        run_table();

        // Reconfig together with run_en: one last update, then frozen.
        a = 4'b1111; b = 4'b1111; run_en = 1'b1; reconfig = 1'b1;
        step();
        reconfig = 1'b0;
        chk("reconf_q", q, 2'b10);
        chk("reconf_ready", cfg_ready, 1'b1);
        chk("reconf_done", cfg_done, 1'b0);
        a = 4'b1110; b = 4'b1110;
        step();
        chk("load_frozen", q, 2'b10);
        run_en = 1'b0;

        load(STREAM, 1'b1, 2'b10, 1'b0, 8'h00);
        run_table();

        // Asynchronous clear in the middle of the 5th bit.
        a = 4'b1111; b = 4'b1111; run_en = 1'b1;
        step();
        chk("pre_clr_q", q, 2'b10);
        reconfig = 1'b1;
        step();
        reconfig = 1'b0; run_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = ~STREAM[i];
            step();
        end
        cfg_bit = ~STREAM[4];
        #2 clr = 1'b0;
        #1;
        chk("clr_q", q, 2'b00);
        chk("clr_ready", cfg_ready, 1'b1);
        chk("clr_done", cfg_done, 1'b0);
        cfg_valid = 1'b0;
        #1 clr = 1'b1;
        step();

        load(STREAM, 1'b0, 2'b00, 1'b0, 8'h00);
        run_table();

        // Reload all zeros; old bitstream comes back out on cfg_out.
        reconfig = 1'b1;
        step();
        reconfig = 1'b0;
        chk("rb_ready", cfg_ready, 1'b1);
        load(8'h00, 1'b0, 2'b00, 1'b1, STREAM);
        a = 4'b1111; b = 4'b1111; run_en = 1'b1;
        step();
        chk("zero_cfg_q", q, 2'b00);
        run_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
